// File: rtl/pe_tile_scheduler_if.sv
// Bundle between pe_tile_scheduler and its environment (tile buffers, PE, control).
// Optional stall_cnt_o exists only when PE_SCHED_STALL_CNT_EN is defined.
interface pe_tile_scheduler_if #(
    parameter int IDX_W = 9,
    parameter int OD_W  = 8
);
    // Handshake: a tile pair is issued on an edge where tile_ready_i is high and
    // fewer than MAX_INFLIGHT tiles are outstanding. data_valid_o/weight_valid_o
    // then pulse for exactly one cycle alongside the indices. The PE has no ready;
    // flow control is the in-flight count closed by pe_result_valid_i pulses.
    logic             start_i;
    logic [IDX_W-1:0] cfg_tiles_x_i;
    logic [IDX_W-1:0] cfg_tiles_y_i;
    logic [OD_W-1:0]  cfg_num_od_i;
    logic             cfg_size_type_i;
    logic             tile_ready_i;
    logic             pe_result_valid_i;

    logic             data_valid_o;
    logic             weight_valid_o;
    logic [IDX_W-1:0] data_x_index_o;
    logic [IDX_W-1:0] data_y_index_o;
    logic [OD_W-1:0]  weight_od_o;
    logic             weight_size_type_o;
    logic [3:0]       inflight_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [1:0]       dbg_state_o;
`ifdef PE_SCHED_STALL_CNT_EN
    logic [15:0]      stall_cnt_o;
`endif

    modport master (
        output start_i, cfg_tiles_x_i, cfg_tiles_y_i, cfg_num_od_i, cfg_size_type_i,
        output tile_ready_i, pe_result_valid_i,
        input  data_valid_o, weight_valid_o, data_x_index_o, data_y_index_o, weight_od_o,
        input  weight_size_type_o, inflight_o, busy_o, done_o, err_o, dbg_state_o
`ifdef PE_SCHED_STALL_CNT_EN
        , input stall_cnt_o
`endif
    );

    modport slave (
        input  start_i, cfg_tiles_x_i, cfg_tiles_y_i, cfg_num_od_i, cfg_size_type_i,
        input  tile_ready_i, pe_result_valid_i,
        output data_valid_o, weight_valid_o, data_x_index_o, data_y_index_o, weight_od_o,
        output weight_size_type_o, inflight_o, busy_o, done_o, err_o, dbg_state_o
`ifdef PE_SCHED_STALL_CNT_EN
        , output stall_cnt_o
`endif
    );
endinterface

// File: rtl/pe_tile_scheduler.sv
// Walks (od, y, x) tile positions of a layer and issues them to one Winograd PE,
// bounding outstanding tiles. Optional stall counter: PE_SCHED_STALL_CNT_EN.
module pe_tile_scheduler #(
    parameter int IDX_W        = 9,
    parameter int OD_W         = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input logic                clk,
    input logic                reset,
    pe_tile_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cfg_x_q, cfg_y_q, cur_x_q, cur_y_q, x_idx_q, y_idx_q;
    logic [OD_W-1:0]  cfg_od_q, cur_od_q, od_idx_q;
    logic             size_type_q, valid_q, err_q;
    logic [3:0]       inflight_q;
    logic             start_ok, cfg_zero, issue, x_last, y_last, od_last, stray;

    assign start_ok = (state_q == S_IDLE) && bus.start_i;
    assign cfg_zero = (bus.cfg_tiles_x_i == '0) || (bus.cfg_tiles_y_i == '0) ||
                      (bus.cfg_num_od_i == '0);
    assign issue    = (state_q == S_ISSUE) && bus.tile_ready_i && (inflight_q < MAX_CNT);
    assign x_last   = (cur_x_q == cfg_x_q - IDX_W'(1));
    assign y_last   = (cur_y_q == cfg_y_q - IDX_W'(1));
    assign od_last  = (cur_od_q == cfg_od_q - OD_W'(1));
    assign stray    = bus.pe_result_valid_i && (inflight_q == 4'd0);

    // Empty layers go through DRAIN (count is already 0) so done_o lands one
    // cycle later, exactly as it does after the last result of a real layer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = cfg_zero ? S_DRAIN : S_ISSUE;
            S_ISSUE: if (issue && x_last && y_last && od_last) state_d = S_DRAIN;
            S_DRAIN: if (inflight_q == 4'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Scan position: x innermost, then y, then od.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_x_q     <= '0;
            cfg_y_q     <= '0;
            cfg_od_q    <= '0;
            size_type_q <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cur_od_q    <= '0;
        end else if (start_ok) begin
            cfg_x_q     <= bus.cfg_tiles_x_i;
            cfg_y_q     <= bus.cfg_tiles_y_i;
            cfg_od_q    <= bus.cfg_num_od_i;
            size_type_q <= bus.cfg_size_type_i;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cur_od_q    <= '0;
        end else if (issue) begin
            if (!x_last) begin
                cur_x_q <= cur_x_q + IDX_W'(1);
            end else begin
                cur_x_q <= '0;
                if (!y_last) begin
                    cur_y_q <= cur_y_q + IDX_W'(1);
                end else begin
                    cur_y_q  <= '0;
                    cur_od_q <= cur_od_q + OD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            x_idx_q  <= '0;
            y_idx_q  <= '0;
            od_idx_q <= '0;
        end else begin
            valid_q <= issue;
            if (issue) begin
                x_idx_q  <= cur_x_q;
                y_idx_q  <= cur_y_q;
                od_idx_q <= cur_od_q;
            end
        end
    end

    // A result with nothing outstanding is flagged and never underflows the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            if (issue && !bus.pe_result_valid_i)
                inflight_q <= inflight_q + 4'd1;
            else if (!issue && bus.pe_result_valid_i && (inflight_q != 4'd0))
                inflight_q <= inflight_q - 4'd1;
            if (stray) err_q <= 1'b1;
        end
    end

`ifdef PE_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= 16'd0;
        else if (start_ok)
            stall_cnt_q <= 16'd0;
        else if ((state_q == S_ISSUE) && !issue && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign bus.stall_cnt_o = stall_cnt_q;
`endif

    assign bus.data_valid_o       = valid_q;
    assign bus.weight_valid_o     = valid_q;
    assign bus.data_x_index_o     = x_idx_q;
    assign bus.data_y_index_o     = y_idx_q;
    assign bus.weight_od_o        = od_idx_q;
    assign bus.weight_size_type_o = size_type_q;
    assign bus.inflight_o         = inflight_q;
    assign bus.busy_o             = (state_q != S_IDLE);
    assign bus.done_o             = (state_q == S_DONE);
    assign bus.err_o              = err_q;
    assign bus.dbg_state_o        = state_q;
endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Bench for pe_tile_scheduler: table of layer configurations run against a
// transaction-level model, plus hand sequences for cap, zero-size and reset cases.
module tb_pe_tile_scheduler;
  localparam int IDX_W   = 9;
  localparam int OD_W    = 8;
  localparam int MAX_INF = 4;
  localparam int PW      = OD_W + 2 * IDX_W;

  typedef struct {
    int x; int y; int od; bit st;
    int pct; int lat_lo; int lat_hi;
    int gap_at; int gap_len;
    int exp_issues;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_tile_scheduler_if #(.IDX_W(IDX_W), .OD_W(OD_W)) bus();

  pe_tile_scheduler #(.IDX_W(IDX_W), .OD_W(OD_W), .MAX_INFLIGHT(MAX_INF)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start_i = 1'b0;
    bus.cfg_tiles_x_i = '0;
    bus.cfg_tiles_y_i = '0;
    bus.cfg_num_od_i = '0;
    bus.cfg_size_type_i = 1'b0;
    bus.tile_ready_i = 1'b0;
    bus.pe_result_valid_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.data_valid_o), 0);
    chk({tag, "_wvalid"}, 32'(bus.weight_valid_o), 0);
    chk({tag, "_pos"}, 32'({bus.weight_od_o, bus.data_y_index_o, bus.data_x_index_o}), 0);
    chk({tag, "_size"}, 32'(bus.weight_size_type_o), 0);
    chk({tag, "_inflight"}, 32'(bus.inflight_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_done"}, 32'(bus.done_o), 0);
    chk({tag, "_err"}, 32'(bus.err_o), 0);
    chk({tag, "_state"}, 32'(bus.dbg_state_o), 0);
`ifdef PE_SCHED_STALL_CNT_EN
    chk({tag, "_stall"}, 32'(bus.stall_cnt_o), 0);
`endif
  endtask

  // Model: issues happen in nested-loop order whenever a slot is free and the
  // buffers are ready; done follows one edge after the last result returns.
  task automatic run_layer(input vec_t v);
    logic [PW-1:0] exp_q[$];
    int pe_q[$];
    logic [PW-1:0] act_pos, held, want;
    int total, n_inf, n_iss, done_edge, stall, due;
    bit rdy, res, exp_iss, finished, have_held;
    total = v.x * v.y * v.od;
    for (int od = 0; od < v.od; od++)
      for (int y = 0; y < v.y; y++)
        for (int x = 0; x < v.x; x++)
          exp_q.push_back({OD_W'(od), IDX_W'(y), IDX_W'(x)});
    bus.cfg_tiles_x_i = IDX_W'(v.x);
    bus.cfg_tiles_y_i = IDX_W'(v.y);
    bus.cfg_num_od_i = OD_W'(v.od);
    bus.cfg_size_type_i = v.st;
    bus.start_i = 1'b1;
    bus.tile_ready_i = 1'b0;
    bus.pe_result_valid_i = 1'b0;
    step();
    bus.start_i = 1'b0;
    bus.cfg_tiles_x_i = IDX_W'($urandom);
    bus.cfg_tiles_y_i = IDX_W'($urandom);
    bus.cfg_num_od_i = OD_W'($urandom);
    bus.cfg_size_type_i = ~v.st;
    chk("start_busy", 32'(bus.busy_o), 1);
    chk("start_valid", 32'(bus.data_valid_o), 0);
    chk("start_inflight", 32'(bus.inflight_o), 0);
    n_inf = 0; n_iss = 0; stall = 0; finished = 0; have_held = 0; held = '0;
    done_edge = (total == 0) ? 1 : -1;
    for (int e = 1; e <= 4000 && !finished; e++) begin
      rdy = ($urandom_range(0, 99) < v.pct);
      if (v.gap_at >= 0 && e >= v.gap_at && e < v.gap_at + v.gap_len) rdy = 0;
      res = (pe_q.size() > 0) && (pe_q[0] <= e);
      bus.tile_ready_i = rdy;
      bus.pe_result_valid_i = res;
      bus.start_i = ($urandom_range(0, 4) == 0);
      step();
      exp_iss = (n_iss < total) && rdy && (n_inf < MAX_INF);
      if (n_iss < total && !exp_iss) stall++;
      chk("valid", 32'(bus.data_valid_o), 32'(exp_iss));
      chk("weight_valid", 32'(bus.weight_valid_o), 32'(exp_iss));
      act_pos = {bus.weight_od_o, bus.data_y_index_o, bus.data_x_index_o};
      if (res) begin
        void'(pe_q.pop_front());
        n_inf--;
      end
      if (exp_iss) begin
        want = exp_q.pop_front();
        chk("issue_pos", 32'(act_pos), 32'(want));
        held = want;
        have_held = 1;
        n_iss++;
        n_inf++;
        due = e + $urandom_range(v.lat_lo, v.lat_hi);
        if (pe_q.size() > 0 && due <= pe_q[$]) due = pe_q[$] + 1;
        pe_q.push_back(due);
      end else if (have_held) begin
        chk("hold_pos", 32'(act_pos), 32'(held));
      end
      chk("inflight", 32'(bus.inflight_o), 32'(n_inf));
      chk("size_type", 32'(bus.weight_size_type_o), 32'(v.st));
      chk("err", 32'(bus.err_o), 0);
      if (done_edge < 0 && n_iss == total && n_inf == 0) done_edge = e + 1;
      chk("done", 32'(bus.done_o), 32'(e == done_edge));
      chk("busy", 32'(bus.busy_o), 32'(done_edge < 0 || e <= done_edge));
      if (done_edge >= 0 && e > done_edge) finished = 1;
    end
    drive_idle();
    if (!finished) chk("layer_timeout", 0, 1);
    chk("issue_count", 32'(n_iss), 32'(v.exp_issues));
`ifdef PE_SCHED_STALL_CNT_EN
    chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(stall));
`endif
  endtask

  // Cap: 4 issues with results withheld, then a result at the full edge frees
  // nothing until the next edge, and issue+result together hold the count.
  task automatic cap_seq();
    bus.cfg_tiles_x_i = IDX_W'(6);
    bus.cfg_tiles_y_i = IDX_W'(1);
    bus.cfg_num_od_i = OD_W'(1);
    bus.start_i = 1'b1;
    bus.tile_ready_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("cap_fill_valid", 32'(bus.data_valid_o), 1);
      chk("cap_fill_x", 32'(bus.data_x_index_o), 32'(i - 1));
      chk("cap_fill_inflight", 32'(bus.inflight_o), 32'(i));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      chk("cap_stall_valid", 32'(bus.data_valid_o), 0);
      chk("cap_stall_inflight", 32'(bus.inflight_o), 4);
    end
    bus.pe_result_valid_i = 1'b1;
    step();
    chk("cap_free_valid", 32'(bus.data_valid_o), 0);
    chk("cap_free_inflight", 32'(bus.inflight_o), 3);
    step();
    chk("cap_both_valid", 32'(bus.data_valid_o), 1);
    chk("cap_both_x", 32'(bus.data_x_index_o), 4);
    chk("cap_both_inflight", 32'(bus.inflight_o), 3);
    bus.pe_result_valid_i = 1'b0;
    step();
    chk("cap_last_x", 32'(bus.data_x_index_o), 5);
    chk("cap_last_inflight", 32'(bus.inflight_o), 4);
    bus.pe_result_valid_i = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("cap_drain_inflight", 32'(bus.inflight_o), 32'(i));
      chk("cap_drain_done", 32'(bus.done_o), 0);
    end
    bus.pe_result_valid_i = 1'b0;
    step();
    chk("cap_done", 32'(bus.done_o), 1);
    step();
    chk("cap_done_end", 32'(bus.done_o), 0);
    chk("cap_busy_end", 32'(bus.busy_o), 0);
    chk("cap_err", 32'(bus.err_o), 0);
    drive_idle();
  endtask

  task automatic reset_seq();
    bus.cfg_tiles_x_i = IDX_W'(2);
    bus.cfg_tiles_y_i = IDX_W'(2);
    bus.cfg_num_od_i = OD_W'(2);
    bus.cfg_size_type_i = 1'b1;
    bus.start_i = 1'b1;
    bus.tile_ready_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    repeat (3) step();
    chk("rst_pre_inflight", 32'(bus.inflight_o), 3);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("rst_async");
    step();
    step();
    chk_zero("rst_held");
    reset = 1'b1;
    drive_idle();
    step();
    bus.pe_result_valid_i = 1'b1;
    step();
    bus.pe_result_valid_i = 1'b0;
    chk("rst_stray_err", 32'(bus.err_o), 1);
    chk("rst_stray_inflight", 32'(bus.inflight_o), 0);
    chk("rst_stray_done", 32'(bus.done_o), 0);
    step();
    chk("rst_err_sticky", 32'(bus.err_o), 1);
    chk("rst_busy", 32'(bus.busy_o), 0);
    reset = 1'b0;
    #1;
    chk("rst_err_clear", 32'(bus.err_o), 0);
    reset = 1'b1;
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    reset = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    step();

    //           x    y  od st  pct lo hi gap len exp
    vecs[0] = '{2,   2, 2, 0, 100, 4, 4, -1, 0, 8};
    vecs[1] = '{3,   1, 1, 1, 100, 2, 2,  2, 5, 3};
    vecs[2] = '{2,   2, 0, 0, 100, 1, 1, -1, 0, 0};
    vecs[3] = '{0,   3, 1, 1, 100, 1, 1, -1, 0, 0};
    vecs[4] = '{511, 1, 1, 1, 100, 3, 3, -1, 0, 511};
    vecs[5] = '{1,   1, 1, 0, 100, 1, 1, -1, 0, 1};
    vecs[6] = '{4,   3, 2, 1,  60, 1, 9, -1, 0, 24};
    vecs[7] = '{1,   5, 1, 0,  50, 5, 12, -1, 0, 5};
    for (int i = 0; i < 8; i++) run_layer(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.x = $urandom_range(1, 4);
      rv.y = $urandom_range(1, 3);
      rv.od = $urandom_range(1, 3);
      rv.st = 1'($urandom_range(0, 1));
      rv.pct = $urandom_range(30, 100);
      rv.lat_lo = 1;
      rv.lat_hi = $urandom_range(1, 10);
      rv.gap_at = -1;
      rv.gap_len = 0;
      rv.exp_issues = rv.x * rv.y * rv.od;
      run_layer(rv);
    end

    cap_seq();
    reset_seq();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
